// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs decoded RV64 base-ISA fields into 32-bit
// words and streams them into instruction memory with a write handshake.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(BASE_ADDR + DEPTH - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_KIND = 2'd1;
  localparam logic [1:0] E_IMM  = 2'd2;
  localparam logic [1:0] E_OVF  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e             state_q;
  logic               in_ready_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [1:0]         err_code_q;
  logic [CNT_W-1:0]   count_q;
  logic               last_q;

  logic [31:0]        enc_d;
  logic [1:0]         enc_err_d;
  logic [CNT_W-1:0]   addr_inc_c;

  // Encode the presented field bundle and classify it as legal or erroneous
  always_comb begin
    enc_d     = 32'd0;
    enc_err_d = E_NONE;
    case (in_kind)
      3'd0: enc_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      3'd1: begin
        enc_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
        if (in_imm[12] != in_imm[11]) enc_err_d = E_IMM;
      end
      3'd2: begin
        enc_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        if (in_imm[12] != in_imm[11]) enc_err_d = E_IMM;
      end
      3'd3: begin
        enc_d = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        if (in_imm[12] != in_imm[11]) enc_err_d = E_IMM;
      end
      3'd4: begin
        enc_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], OP_BRANCH};
        if (in_imm[0]) enc_err_d = E_IMM;
      end
      default: enc_err_d = E_KIND;
    endcase
  end

  // Widened so the last legal address plus one is representable
  assign addr_inc_c = CNT_W'(mem_addr_q) + CNT_W'(1);

  // Load sequencer with registered handshake, address and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= E_NONE;
      count_q     <= '0;
      last_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
            mem_addr_q <= BASE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (in_valid && in_ready_q) begin
            last_q <= in_last;
            if (enc_err_d == E_NONE) begin
              mem_wdata_q <= enc_d;
              mem_we_q    <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= S_WRITE;
            end else begin
              // Bad bundle is consumed and dropped; first error code is kept
              err_q <= 1'b1;
              if (!err_q) err_code_q <= enc_err_d;
              if (in_last) begin
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= S_DONE;
              end
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= ADDR_W'(addr_inc_c);
            count_q    <= count_q + CNT_W'(1);
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (addr_inc_c > LAST_ADDR) begin
              err_q <= 1'b1;
              if (!err_q) err_code_q <= E_OVF;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_ACCEPT;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: full-depth instance plus a DEPTH=4
// instance for the overflow case.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [12:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        mem_ready = 1'b1;

  logic        in_ready, mem_we, busy, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [10:0] count;

  logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
  logic [9:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [1:0]  s_err_code;
  logic [10:0] s_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
  );

  instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(s_mem_we), .mem_ready(mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_err_code), .count(s_count)
  );

  // Write logs of completed memory handshakes for each instance
  logic [9:0]  wa [0:31];
  logic [31:0] wd [0:31];
  int          nw = 0;
  logic [9:0]  s_wa [0:31];
  logic [31:0] s_wd [0:31];
  int          s_nw = 0;

  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ready && nw < 32) begin
      wa[nw] <= mem_addr;
      wd[nw] <= mem_wdata;
      nw     <= nw + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && s_mem_we && mem_ready && s_nw < 32) begin
      s_wa[s_nw] <= s_mem_addr;
      s_wd[s_nw] <= s_mem_wdata;
      s_nw       <= s_nw + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Present one bundle at a falling edge and hold it until accepted
  task automatic send(input bit sel, input logic [2:0] k, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [12:0] imm, input bit last);
    int cyc = 0;
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    while (!(sel ? s_in_ready : in_ready) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept", 64'(cyc < 40), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int cyc = 0;
    while (!(sel ? s_done : done) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(cyc < 40), 64'd1);
  endtask

  int b;

  initial begin
    // Reset values
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'({err, err_code}), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single addi x1,x0,5
    b = nw;
    do_start(0);
    chk("t1_ready", 64'(in_ready), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    send(0, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 1'b1);
    wait_done(0);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_nw", 64'(nw - b), 64'd1);
    chk("t1_addr", 64'(wa[b]), 64'd0);
    chk("t1_data", 64'(wd[b]), 64'h00500093);
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Stream add / sw / beq
    b = nw;
    do_start(0);
    send(0, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    send(0, 3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'd8, 1'b0);
    send(0, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b1);
    wait_done(0);
    chk("t2_count", 64'(count), 64'd3);
    chk("t2_nw", 64'(nw - b), 64'd3);
    chk("t2_w0", 64'({wa[b], wd[b]}), {22'd0, 10'd0, 32'h002081B3});
    chk("t2_w1", 64'({wa[b+1], wd[b+1]}), {22'd0, 10'd1, 32'h0020A423});
    chk("t2_w2", 64'({wa[b+2], wd[b+2]}), {22'd0, 10'd2, 32'hFE208EE3});
    chk("t2_err", 64'(err), 64'd0);

    // lw x5,-1(x0) with a 5-cycle memory stall
    b = nw;
    do_start(0);
    mem_ready = 1'b0;
    send(0, 3'd2, 5'd5, 5'd0, 5'd0, 3'd2, 7'd0, 13'h1FFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", 64'({mem_we, mem_addr, mem_wdata}), {21'd0, 1'b1, 10'd0, 32'hFFF02283});
      @(negedge clk);
    end
    chk("t3_nw_stall", 64'(nw - b), 64'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t3_we_drop", 64'(mem_we), 64'd0);
    chk("t3_count", 64'(count), 64'd1);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_write", 64'({wa[b], wd[b]}), {22'd0, 10'd0, 32'hFFF02283});
    chk("t3_addr_next", 64'(mem_addr), 64'd1);

    // Illegal kind then addi
    b = nw;
    do_start(0);
    send(0, 3'd6, 5'd7, 5'd7, 5'd7, 3'd0, 7'd0, 13'd0, 1'b0);
    send(0, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 1'b1);
    wait_done(0);
    chk("t4_err", 64'({err, err_code}), 64'({1'b1, 2'd1}));
    chk("t4_nw", 64'(nw - b), 64'd1);
    chk("t4_write", 64'({wa[b], wd[b]}), {22'd0, 10'd0, 32'h00500093});
    chk("t4_count", 64'(count), 64'd1);

    // I-ALU immediate out of range
    b = nw;
    do_start(0);
    chk("t5_err_cleared", 64'({err, err_code}), 64'd0);
    send(0, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800, 1'b1);
    wait_done(0);
    chk("t5_err", 64'({err, err_code}), 64'({1'b1, 2'd2}));
    chk("t5_nw", 64'(nw - b), 64'd0);
    chk("t5_count", 64'(count), 64'd0);

    // Overflow on the DEPTH=4 instance
    do_start(1);
    for (int i = 1; i <= 4; i++)
      send(1, 3'd1, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b0);
    wait_done(1);
    chk("t6_err", 64'({s_err, s_err_code}), 64'({1'b1, 2'd3}));
    chk("t6_count", 64'(s_count), 64'd4);
    chk("t6_nw", 64'(s_nw), 64'd4);
    chk("t6_w3", 64'({s_wa[3], s_wd[3]}), {22'd0, 10'd3, 32'h00000213});
    chk("t6_addr", 64'(s_mem_addr), 64'd4);
    in_kind = 3'd1; in_rd = 5'd5; in_imm = 13'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_ready", 64'(s_in_ready), 64'd0);
    end
    in_valid = 1'b0;
    chk("t6_nw_after", 64'(s_nw), 64'd4);
    chk("t6_idle", 64'(s_busy), 64'd0);

    // Reset during a stalled write
    do_start(0);
    send(0, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    send(0, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    chk("t7_stalled", 64'({mem_we, count}), 64'({1'b1, 11'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("t7_we_async", 64'(mem_we), 64'd0);
    chk("t7_busy_async", 64'(busy), 64'd0);
    chk("t7_count_async", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    b = nw;
    do_start(0);
    send(0, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 1'b1);
    wait_done(0);
    chk("t7_nw", 64'(nw - b), 64'd1);
    chk("t7_write", 64'({wa[b], wd[b]}), {22'd0, 10'd0, 32'hFE208EE3});
    chk("t7_count", 64'(count), 64'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Reverse of the opcode control decoder: packs decoded instruction fields into 32-bit RV64 base-ISA words and writes them sequentially into instruction memory.
- Used to load test programs into the single-cycle core's instruction memory.
- Supports the same five instruction classes the core decodes: R-type ALU, I-type ALU, load, store, branch.
- Sequential block: start/last framing, valid/ready field input, write handshake toward memory, address counter, error flags.

Parameters:
ADDR_W, 10, width of the word address to instruction memory
BASE_ADDR, 0, word address of the first instruction written
DEPTH, 1024, words available; last legal address is BASE_ADDR+DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a program load; honoured only in IDLE
in_valid  in  1  field bundle valid
in_ready  out  1  block accepts the bundle this cycle
in_kind  in  3  0=R-ALU, 1=I-ALU, 2=load, 3=store, 4=branch; 5-7 illegal
in_rd, in_rs1, in_rs2  in  5 each  register indices
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field (R-type only)
in_imm  in  13  signed immediate, byte offset for branch
in_last  in  1  marks the final bundle of the program
mem_we  out  1  write request
mem_ready  in  1  memory accepts the write when mem_we&mem_ready
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a load completes
err  out  1  sticky error, cleared by start
err_code  out  2  0=none, 1=illegal kind, 2=immediate out of range, 3=overflow (first error wins)
count  out  ADDR_W+1  words written in the current load

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, err_code=0, count=0.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - start=1: clears count, err and err_code; sets mem_addr=BASE_ADDR; goes to ACCEPT.
  - start in any other state is ignored.
- ACCEPT:
  - in_ready=1 in this state only.
  - On in_valid&in_ready, the fields are encoded and registered, and in_last is latched.
  - Valid bundle: mem_wdata is loaded; next state is WRITE, with mem_we=1 on the next cycle (1-cycle latency).
  - Invalid bundle: no write; err set; next state is DONE if in_last, else ACCEPT.
- WRITE:
  - mem_we, mem_addr and mem_wdata are held stable until mem_ready.
  - On handshake: mem_we drops, mem_addr+1, count+1.
  - Next state is DONE if the latched last flag is set; otherwise ACCEPT.
  - If the new mem_addr would exceed BASE_ADDR+DEPTH-1 and last is not set: err, code 3, go to DONE.
  - Peak throughput: one word per 2 cycles.
- DONE: done=1 for exactly one cycle, then IDLE.
- Encodings (opcodes match the core's decoder):
  - R-ALU: funct7|rs2|rs1|funct3|rd|0110011
  - I-ALU: imm[11:0]|rs1|funct3|rd|0010011
  - Load: imm[11:0]|rs1|funct3|rd|0000011
  - Store: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
  - Branch: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011
- Immediate rules:
  - I-ALU, load, store: in_imm[12] must equal in_imm[11] (fits 12-bit signed), else code 2.
  - Branch: in_imm[0] must be 0, else code 2.
  - R-type: in_imm is ignored.
- Unused fields are ignored. Illegal kinds 5-7 raise code 1.
- An error never aborts the load except on overflow. Erroneous bundles are consumed and dropped; the address does not advance.
- Mid-operation reset: all state clears immediately. A partially held write is abandoned, and mem_we falls asynchronously.

Test Plan:
- start; addi x1,x0,5 (kind1, rd1, imm5, last=1) -> mem_wdata=0x00500093 at addr 0, done pulse, count=1.
- Stream: add x3,x1,x2 (kind0); sw x2,8(x1) (kind3, f3=2); beq x1,x2,-4 (kind4, imm=0x1FFC, last) -> writes 0x002081B3@0, 0x0020A423@1, 0xFE208EE3@2; count=3.
- lw x5,-1(x0) (kind2, f3=2, imm=0x1FFF) with mem_ready held low 5 cycles -> mem_we, mem_addr and mem_wdata=0xFFF02283 stable all 5 cycles; write completes on the cycle mem_ready rises.
- Errors:
  - kind=6 then addi -> err=1, code 1; only the addi is written, at addr 0.
  - I-ALU imm=0x0800 -> code 2, nothing written.
- DEPTH=4: five bundles, no last -> 4 writes, err code 3, done pulse, fifth bundle not accepted.
- rst_n low during WRITE stall -> mem_we=0, busy=0, count=0 immediately. A new start then writes from BASE_ADDR.
